lii_tx_packetizer: RTL and testbench
====================================

# lii_tx_packetizer

Endpoint-side transmitter for the LII stream protocol. It turns a message command (destination, type, byte length) plus a raw payload word stream into LII beats that feed one router input port. It generates src, keep/strb and last, and splits long messages into packets of at most MAX_BEATS beats. A single registered output stage isolates router backpressure timing from the payload source.

## Interface
- DW, 256: data width in bits; DW/8 (BPB) must be a power of two.
- SRC_W, 8: source ID width.
- DST_W, 8: destination ID width.
- TYPE_W, 2: message type width.
- LEN_W, 16: byte-length field width.
- MAX_BEATS, 16: maximum beats per packet (≥1).
- LOCAL_ID, 0: value driven on m_src.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted; high only in IDLE.
- cmd_dst  in  DST_W  destination for all beats of the message.
- cmd_type  in  TYPE_W  type for all beats.
- cmd_len  in  LEN_W  message length in bytes.
- pay_data  in  DW  payload word; byte 0 is in bits [7:0].
- pay_valid  in  1  payload word present.
- pay_ready  out  1  payload word consumed.
- m_data/m_keep/m_strb/m_last/m_src/m_dst/m_type  out  DW/BPB/BPB/1/SRC_W/DST_W/TYPE_W  LII beat fields.
- m_valid  out  1  beat present.
- m_ready  in  1  router accepts the beat.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when a message completes.

## Operation
- States: IDLE, SEND, DRAIN.
- IDLE → SEND on cmd_valid&cmd_ready with cmd_len>0.
  - Latch dst and type.
  - beats_left = ceil(len/BPB).
  - tail = len mod BPB.
  - seg_cnt = 0.
- IDLE with cmd_len==0: the command is accepted and no beat is emitted. done pulses the next cycle; the state stays IDLE.
- SEND: pay_ready = !m_valid | m_ready.
  - On pay_valid&pay_ready, the output register loads the payload word and fields, and beats_left decrements.
  - SEND → DRAIN when the loaded word is the final one (beats_left==1).
- DRAIN: pay_ready=0. DRAIN → IDLE on m_valid&m_ready; done pulses in the cycle after that edge.
- keep:
  - Every beat except the final beat of the message gets all ones.
  - The final beat gets (1<<tail)-1, or all ones if tail==0.
  - strb = keep.
- last: asserted on the final beat of the message, or when seg_cnt reaches MAX_BEATS-1.
  - seg_cnt increments per loaded beat and resets to 0 after each last beat.
  - Split packets keep the same dst/type/src.
- m_src = LOCAL_ID on every valid beat.
- Payload words beyond the message length are never consumed; the source must not pre-present the next message's data as belonging to the current one.

## Timing
- Reset values: m_valid=0, m_last=0, all m_* data fields 0, done=0, busy=0, cmd_ready=1 (state IDLE).
- Latency: a payload word accepted at edge N is on m_* with m_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while m_ready=1 and pay_valid=1.
- LII rule: once m_valid=1, m_valid and all m_* fields hold until m_ready=1.
- pay_ready depends combinationally on m_ready. This is the only combinational in→out path.
- Simultaneous drain and load: when m_valid&m_ready and pay_valid&pay_ready coincide, the register holds the new beat and m_valid stays 1.
- Between messages: cmd_ready returns high in the cycle after the final handshake. Minimum 2 idle cycles between messages on m_*.
- Reset asserted mid-message: the beat in flight is dropped and the state returns to IDLE immediately. No done pulse. The partial packet is not terminated (the router-side FIFO is reset on the same rstn).
- Width rules:
  - beats_left is LEN_W bits.
  - tail is log2(BPB) bits.
  - seg_cnt is clog2(MAX_BEATS)+1 bits.
  - ceil is computed as (len+BPB-1)>>log2(BPB) at LEN_W+1 bits, so there is no overflow at len=2^LEN_W-1.

## Structure
- Shared package lii_pkg holds:
  - the LII width defaults (DW, SRC_W, DST_W, TYPE_W);
  - a BPB localparam;
  - the keep-mask-from-tail function, also used by the future receive-side depacketizer;
  - the state encoding.
- Single module. The output register is inline; no sub-module is needed.

## Test plan
- DW=256, len=64, dst=0x80, type=1, m_ready=1 → 2 beats, both keep=0xFFFFFFFF; last only on beat 2; src=LOCAL_ID; done 1 cycle after beat 2.
- len=33 → 2 beats; beat 2 keep=strb=0x00000001 and last=1; exactly 2 payload words consumed.
- len=1280 (40 beats), MAX_BEATS=16 → last on beats 16, 32, 40; dst/type identical on all beats.
- len=256 with random m_ready (30% low) and pay_valid gaps → m_* stable while m_valid&!m_ready; no beat lost or duplicated; data order matches input.
- cmd_len=0 → no m_valid; done pulses once; cmd_ready high again immediately; a following len=32 message emits 1 beat with last=1.
- rstn low during beat 3 of 8 → m_valid=0 and busy=0 asynchronously; after release cmd_ready=1 and a new 2-beat message completes normally.

Source files
------------

// File: rtl/lii_pkg.sv
// Shared LII definitions: default widths, state encoding and keep-mask helper.
package lii_pkg;

  localparam int unsigned LII_DW     = 256;
  localparam int unsigned LII_SRC_W  = 8;
  localparam int unsigned LII_DST_W  = 8;
  localparam int unsigned LII_TYPE_W = 2;
  localparam int unsigned LII_LEN_W  = 16;
  localparam int unsigned LII_BPB    = LII_DW / 8;
  localparam int unsigned LII_TAIL_W = $clog2(LII_BPB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  // Valid-byte mask for a final beat holding 'tail' bytes (0 means a full beat).
  function automatic logic [LII_BPB-1:0] keep_from_tail(input logic [LII_TAIL_W-1:0] tail);
    logic [LII_BPB-1:0] k;
    if (tail == '0) k = '1;
    else            k = (LII_BPB'(1) << tail) - LII_BPB'(1);
    return k;
  endfunction

endpackage

// File: rtl/lii_tx_packetizer_if.sv
// Command, payload and LII beat channels of the transmit packetizer.
// master = packetizer side, slave = endpoint/router environment side.
interface lii_tx_packetizer_if import lii_pkg::*; #(
  parameter int unsigned DW     = LII_DW,
  parameter int unsigned SRC_W  = LII_SRC_W,
  parameter int unsigned DST_W  = LII_DST_W,
  parameter int unsigned TYPE_W = LII_TYPE_W,
  parameter int unsigned LEN_W  = LII_LEN_W
) ();

  localparam int unsigned BPB = DW / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DST_W-1:0]  cmd_dst;
  logic [TYPE_W-1:0] cmd_type;
  logic [LEN_W-1:0]  cmd_len;

  logic [DW-1:0]     pay_data;
  logic              pay_valid;
  logic              pay_ready;

  logic [DW-1:0]     m_data;
  logic [BPB-1:0]    m_keep;
  logic [BPB-1:0]    m_strb;
  logic              m_last;
  logic [SRC_W-1:0]  m_src;
  logic [DST_W-1:0]  m_dst;
  logic [TYPE_W-1:0] m_type;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  cmd_valid, cmd_dst, cmd_type, cmd_len, pay_data, pay_valid, m_ready,
    output cmd_ready, pay_ready, m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type, m_valid
  );

  modport slave (
    output cmd_valid, cmd_dst, cmd_type, cmd_len, pay_data, pay_valid, m_ready,
    input  cmd_ready, pay_ready, m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type, m_valid
  );

endinterface

// File: rtl/lii_tx_packetizer.sv
// Endpoint transmitter: turns a message command plus payload words into LII
// beats, splitting long messages into packets of at most MAX_BEATS beats.
module lii_tx_packetizer import lii_pkg::*; #(
  parameter int unsigned DW        = LII_DW,
  parameter int unsigned SRC_W     = LII_SRC_W,
  parameter int unsigned DST_W     = LII_DST_W,
  parameter int unsigned TYPE_W    = LII_TYPE_W,
  parameter int unsigned LEN_W     = LII_LEN_W,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned LOCAL_ID  = 0
) (
  input  logic                clk,
  input  logic                rstn,
  lii_tx_packetizer_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BPB    = DW / 8;
  localparam int unsigned TAIL_W = $clog2(BPB);
  localparam int unsigned SEG_W  = $clog2(MAX_BEATS) + 1;

  tx_state_t         state;
  logic [LEN_W-1:0]  beats_left;
  logic [TAIL_W-1:0] tail_q;
  logic [SEG_W-1:0]  seg_cnt;
  logic [DST_W-1:0]  dst_q;
  logic [TYPE_W-1:0] type_q;

  logic              m_valid_q;
  logic [DW-1:0]     m_data_q;
  logic [BPB-1:0]    m_keep_q;
  logic              m_last_q;
  logic [SRC_W-1:0]  m_src_q;
  logic [DST_W-1:0]  m_dst_q;
  logic [TYPE_W-1:0] m_type_q;
  logic              done_q;

  logic              pay_ready;
  logic              load;
  logic              final_beat;
  logic              seg_end;
  logic [LEN_W:0]    len_round;
  logic [LEN_W-1:0]  beats_init;

  // Output register may take a new word when empty or being drained this cycle.
  assign pay_ready  = (state == ST_SEND) && (!m_valid_q || bus.m_ready);
  assign load       = bus.pay_valid && pay_ready;
  assign final_beat = (beats_left == LEN_W'(1));
  assign seg_end    = (seg_cnt == SEG_W'(MAX_BEATS - 1));
  // One extra bit so the round-up cannot overflow at the maximum length.
  assign len_round  = {1'b0, bus.cmd_len} + (LEN_W + 1)'(BPB - 1);
  assign beats_init = LEN_W'(len_round >> TAIL_W);

  // Control FSM plus the single registered LII output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      tail_q     <= '0;
      seg_cnt    <= '0;
      dst_q      <= '0;
      type_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_src_q    <= '0;
      m_dst_q    <= '0;
      m_type_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              dst_q      <= bus.cmd_dst;
              type_q     <= bus.cmd_type;
              beats_left <= beats_init;
              tail_q     <= bus.cmd_len[TAIL_W-1:0];
              seg_cnt    <= '0;
              state      <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (load) begin
            m_valid_q  <= 1'b1;
            m_data_q   <= bus.pay_data;
            m_keep_q   <= final_beat ? BPB'(keep_from_tail(LII_TAIL_W'(tail_q))) : '1;
            m_last_q   <= final_beat || seg_end;
            m_src_q    <= SRC_W'(LOCAL_ID);
            m_dst_q    <= dst_q;
            m_type_q   <= type_q;
            seg_cnt    <= (final_beat || seg_end) ? '0 : seg_cnt + SEG_W'(1);
            beats_left <= beats_left - LEN_W'(1);
            if (final_beat) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_valid_q && bus.m_ready) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.pay_ready = pay_ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_keep    = m_keep_q;
  assign bus.m_strb    = m_keep_q;
  assign bus.m_last    = m_last_q;
  assign bus.m_src     = m_src_q;
  assign bus.m_dst     = m_dst_q;
  assign bus.m_type    = m_type_q;
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_lii_tx_packetizer.sv
// Bench for lii_tx_packetizer: random payloads and handshakes checked against a
// message-level reference model (byte counts -> beats, keep masks, packet ends).
module tb_lii_tx_packetizer;

  localparam int unsigned DW        = 256;
  localparam int unsigned SRC_W     = 8;
  localparam int unsigned DST_W     = 8;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned LOCAL_ID  = 'h5A;

  logic clk;
  logic rstn;
  logic busy;
  logic done;

  int checks   = 0;
  int failures = 0;

  lii_tx_packetizer_if #(.DW(DW), .SRC_W(SRC_W), .DST_W(DST_W), .TYPE_W(TYPE_W), .LEN_W(LEN_W)) bus ();

  lii_tx_packetizer #(
    .DW(DW), .SRC_W(SRC_W), .DST_W(DST_W), .TYPE_W(TYPE_W), .LEN_W(LEN_W),
    .MAX_BEATS(MAX_BEATS), .LOCAL_ID(LOCAL_ID)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [338:0] beat_vec();
    return {bus.m_data, bus.m_keep, bus.m_strb, bus.m_last, bus.m_src, bus.m_dst, bus.m_type};
  endfunction

  // Send one message; abort_beat >= 0 asserts reset while that beat index is presented.
  task automatic run_msg(input int len, input logic [7:0] dst, input logic [1:0] typ,
                         input int rdy_pct, input int pv_pct, input int abort_beat);
    logic [255:0] words[$];
    logic [31:0]  ekeep[$];
    logic         elast[$];
    logic [338:0] snap;
    logic [255:0] w;
    logic [31:0]  k;
    int n, widx, oidx, cyc;
    bit hold, done_due, fin, fin_next, aborted;

    n = (len + 31) / 32;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom();
      words.push_back(w);
      for (int b = 0; b < 32; b++) k[b] = ((i * 32 + b) < len);
      ekeep.push_back(k);
      elast.push_back((i == n - 1) || (((i + 1) % MAX_BEATS) == 0));
    end

    @(negedge clk);
    check("cmd_ready_idle", 512'(bus.cmd_ready), 512'(1'b1));
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_dst   = dst;
    bus.cmd_type  = typ;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_after_cmd", 512'(busy), 512'(1'b1));

    widx = 0; oidx = 0; cyc = 0;
    hold = 0; done_due = 0; fin = 0; fin_next = 0; aborted = 0;
    snap = '0;
    while (!fin && cyc < 4000) begin
      bus.m_ready   = ($urandom_range(99) < rdy_pct);
      bus.pay_valid = (widx < n) ? ($urandom_range(99) < pv_pct) : ($urandom_range(1) == 1);
      bus.pay_data  = (widx < n) ? words[widx] : {8{$urandom()}};
      #1;
      check("done", 512'(done), 512'(done_due));
      if (fin_next) fin = 1;
      done_due = 0;
      check("pay_ready", 512'(bus.pay_ready), 512'((widx < n) && (!bus.m_valid || bus.m_ready)));
      if (hold) begin
        check("hold_valid", 512'(bus.m_valid), 512'(1'b1));
        check("hold_fields", 512'(beat_vec()), 512'(snap));
      end
      hold = 0;
      if (oidx >= n) check("no_extra_beat", 512'(bus.m_valid), 512'(1'b0));
      if (abort_beat >= 0 && bus.m_valid && oidx == abort_beat) begin
        bus.pay_valid = 1'b0;
        bus.m_ready   = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_m_valid", 512'(bus.m_valid), 512'(1'b0));
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_m_last", 512'(bus.m_last), 512'(1'b0));
        check("rst_m_data", 512'(bus.m_data), 512'(0));
        check("rst_done", 512'(done), 512'(1'b0));
        aborted = 1;
        fin = 1;
      end else begin
        if (bus.m_valid && bus.m_ready && oidx < n) begin
          check("data", 512'(bus.m_data), 512'(words[oidx]));
          check("keep", 512'(bus.m_keep), 512'(ekeep[oidx]));
          check("strb", 512'(bus.m_strb), 512'(ekeep[oidx]));
          check("last", 512'(bus.m_last), 512'(elast[oidx]));
          check("src_dst_type", 512'({bus.m_src, bus.m_dst, bus.m_type}),
                512'({8'(LOCAL_ID), dst, typ}));
          oidx++;
          if (oidx == n) begin
            done_due = 1;
            fin_next = 1;
          end
        end else if (bus.m_valid && !bus.m_ready) begin
          hold = 1;
          snap = beat_vec();
        end
        if (bus.pay_valid && bus.pay_ready) widx++;
        @(negedge clk);
        cyc++;
      end
    end

    bus.pay_valid = 1'b0;
    bus.m_ready   = 1'b0;
    if (!aborted) begin
      check("beats_out", 512'(oidx), 512'(n));
      check("words_consumed", 512'(widx), 512'(n));
      check("done_single", 512'(done), 512'(1'b0));
      check("idle_busy", 512'(busy), 512'(1'b0));
      check("idle_cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));
    end
  endtask

  initial begin
    rstn          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_type  = '0;
    bus.pay_valid = 1'b0;
    bus.pay_data  = '0;
    bus.m_ready   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_m_valid0", 512'(bus.m_valid), 512'(1'b0));
    check("rst_m_last0", 512'(bus.m_last), 512'(1'b0));
    check("rst_m_data0", 512'(bus.m_data), 512'(0));
    check("rst_m_keep0", 512'(bus.m_keep), 512'(0));
    check("rst_m_src0", 512'(bus.m_src), 512'(0));
    check("rst_done0", 512'(done), 512'(1'b0));
    check("rst_busy0", 512'(busy), 512'(1'b0));
    check("rst_cmd_ready0", 512'(bus.cmd_ready), 512'(1'b1));
    rstn = 1'b1;
    @(negedge clk);

    run_msg(64,   8'h80, 2'd1, 100, 100, -1);
    run_msg(33,   8'h12, 2'd2, 100, 100, -1);
    run_msg(1280, 8'h44, 2'd3, 100, 100, -1);
    run_msg(256,  8'h9C, 2'd0, 70,  75,  -1);

    // Zero-length command: accepted, no beats, single done pulse.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = '0;
    bus.cmd_dst   = 8'h77;
    bus.cmd_type  = 2'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("zero_done", 512'(done), 512'(1'b1));
    check("zero_cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));
    check("zero_busy", 512'(busy), 512'(1'b0));
    check("zero_m_valid", 512'(bus.m_valid), 512'(1'b0));
    @(negedge clk);
    check("zero_done_clear", 512'(done), 512'(1'b0));
    run_msg(32, 8'h21, 2'd1, 100, 100, -1);

    // Reset while beat 3 of 8 is on the output.
    run_msg(256, 8'h33, 2'd2, 100, 100, 2);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));
    check("post_rst_m_valid", 512'(bus.m_valid), 512'(1'b0));
    run_msg(50, 8'h5E, 2'd3, 100, 100, -1);

    for (int t = 0; t < 6; t++) begin
      run_msg(int'($urandom_range(700, 1)), 8'($urandom()), 2'($urandom()), 65, 80, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
